// File: rtl/iic_pkg.sv
// Shared encodings for the IIC slave: FSM states, the R/W bit position and ACK levels.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        ACK_DEV   = 4'd2,
        WORD_ADDR = 4'd3,
        ACK_WORD  = 4'd4,
        WR_DATA   = 4'd5,
        ACK_WR    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8
    } state_t;

    localparam int   RW_BIT = 0;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;

endpackage

// File: rtl/iic_bus_sync.sv
// Synchronizes SCL/SDA into I_clk and derives SCL edge pulses plus START/STOP detects.
module iic_bus_sync #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_scl,
    input  logic I_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [P_SYNC_STAGES-1:0] scl_sync;
    logic [P_SYNC_STAGES-1:0] sda_sync;
    logic                     scl_hist;
    logic                     sda_hist;
    logic                     scl_s;

    // Reset to an idle (released, pulled-up) bus so no edge is seen on exit.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[P_SYNC_STAGES-2:0], I_scl};
            sda_sync <= {sda_sync[P_SYNC_STAGES-2:0], I_sda};
            scl_hist <= scl_s;
            sda_hist <= sda_s;
        end
    end

    assign scl_s     = scl_sync[P_SYNC_STAGES-1];
    assign sda_s     = sda_sync[P_SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

endmodule

// File: rtl/iic_slave_regif.sv
// IIC slave for random write / random read transactions toward an 8-bit-addressed sync RAM.
// O_wr_en is a one-cycle strobe with no back-pressure; O_rd_addr is the live pointer and
// I_rd_data must follow it one I_clk later.
module iic_slave_regif
    import iic_pkg::*;
#(
    parameter logic [6:0] P_DEV_ADDR    = 7'h50,
    parameter int         P_SYNC_STAGES = 2
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_scl,
    inout  wire        IO_sda,
    output logic       O_wr_en,
    output logic [7:0] O_wr_addr,
    output logic [7:0] O_wr_data,
    output logic [7:0] O_rd_addr,
    input  logic [7:0] I_rd_data,
    output logic       O_busy
);

    logic       scl_rise;
    logic       scl_fall;
    logic       sda_s;
    logic       start_det;
    logic       stop_det;
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shifter;
    logic [7:0] rx_byte;
    logic [7:0] pointer;
    logic       sda_low;
    logic       rw;
    logic       ack_drv;
    logic       ptr_inc;

    iic_bus_sync #(
        .P_SYNC_STAGES(P_SYNC_STAGES)
    ) u_bus_sync (
        .I_clk    (I_clk),
        .I_rst_n  (I_rst_n),
        .I_scl    (I_scl),
        .I_sda    (IO_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign rx_byte   = {shifter[6:0], sda_s};
    assign IO_sda    = sda_low ? 1'b0 : 1'bz;
    assign O_rd_addr = pointer;

    // ACK_* states: first scl_fall starts driving ACK, second scl_fall ends the ACK clock.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shifter   <= 8'h00;
            pointer   <= 8'h00;
            sda_low   <= 1'b0;
            rw        <= 1'b0;
            ack_drv   <= 1'b0;
            ptr_inc   <= 1'b0;
            O_wr_en   <= 1'b0;
            O_wr_addr <= 8'h00;
            O_wr_data <= 8'h00;
            O_busy    <= 1'b0;
        end else begin
            O_wr_en <= 1'b0;
            if (ptr_inc) begin
                pointer <= pointer + 8'd1;
                ptr_inc <= 1'b0;
            end
            if (start_det) begin
                state   <= DEV_ADDR;
                bit_cnt <= 3'd0;
                sda_low <= 1'b0;
                ack_drv <= 1'b0;
                O_busy  <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                sda_low <= 1'b0;
                ack_drv <= 1'b0;
                O_busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    DEV_ADDR: if (scl_rise) begin
                        shifter <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == P_DEV_ADDR) begin
                                rw      <= rx_byte[RW_BIT];
                                ack_drv <= 1'b0;
                                state   <= ACK_DEV;
                            end else begin
                                state  <= IDLE;
                                O_busy <= 1'b0;
                            end
                        end
                    end
                    WORD_ADDR, WR_DATA: if (scl_rise) begin
                        shifter <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_drv <= 1'b0;
                            if (state == WORD_ADDR) begin
                                pointer <= rx_byte;
                                state   <= ACK_WORD;
                            end else begin
                                O_wr_en   <= 1'b1;
                                O_wr_addr <= pointer;
                                O_wr_data <= rx_byte;
                                ptr_inc   <= 1'b1;
                                state     <= ACK_WR;
                            end
                        end
                    end
                    ACK_DEV, ACK_WORD, ACK_WR: if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_low <= 1'b1;
                            ack_drv <= 1'b1;
                        end else begin
                            ack_drv <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (state == ACK_DEV && rw) begin
                                shifter <= I_rd_data;
                                sda_low <= ~I_rd_data[7];
                                state   <= RD_DATA;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= (state == ACK_DEV) ? WORD_ADDR : WR_DATA;
                            end
                        end
                    end
                    RD_DATA: if (scl_fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            sda_low <= 1'b0;
                            ack_drv <= 1'b0;
                            state   <= RD_ACK;
                        end else begin
                            sda_low <= ~shifter[6];
                            shifter <= {shifter[6:0], 1'b0};
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            pointer <= pointer + 8'd1;
                            if (sda_s == NACK) begin
                                state  <= IDLE;
                                O_busy <= 1'b0;
                            end else begin
                                ack_drv <= 1'b1;
                            end
                        end else if (scl_fall && ack_drv) begin
                            ack_drv <= 1'b0;
                            bit_cnt <= 3'd0;
                            shifter <= I_rd_data;
                            sda_low <= ~I_rd_data[7];
                            state   <= RD_DATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_regif.sv
// Bench for iic_slave_regif: bus-level IIC master tasks, sync RAM model and write/read scoreboards.
module tb_iic_slave_regif;

  localparam int Q = 10;  // I_clk cycles per SCL quarter period

  logic       I_clk;
  logic       I_rst_n;
  logic       I_scl;
  logic       sda_m_low;
  wire        sda_line;
  logic       O_wr_en;
  logic [7:0] O_wr_addr;
  logic [7:0] O_wr_data;
  logic [7:0] O_rd_addr;
  logic [7:0] I_rd_data;
  logic       O_busy;

  int checks = 0;
  int errors = 0;
  int hold_viol = 0;

  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  ram[256];
  logic [7:0]  model_mem[256];
  logic [7:0]  wbuf[8];

  assign sda_line = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  iic_slave_regif #(
    .P_DEV_ADDR   (7'h50),
    .P_SYNC_STAGES(2)
  ) dut (
    .I_clk    (I_clk),
    .I_rst_n  (I_rst_n),
    .I_scl    (I_scl),
    .IO_sda   (sda_line),
    .O_wr_en  (O_wr_en),
    .O_wr_addr(O_wr_addr),
    .O_wr_data(O_wr_data),
    .O_rd_addr(O_rd_addr),
    .I_rd_data(I_rd_data),
    .O_busy   (O_busy)
  );

  // clock / reset
  initial begin
    I_clk = 1'b0;
    forever #10 I_clk = ~I_clk;
  end

  // synchronous RAM behind the register port
  always @(posedge I_clk) begin
    if (O_wr_en) ram[O_wr_addr] <= O_wr_data;
    I_rd_data <= ram[O_rd_addr];
  end

  // write scoreboard: every strobe must match the oldest expected write
  always @(negedge I_clk) begin
    if (O_wr_en === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%02h data=%02h, expected no write", O_wr_addr, O_wr_data);
      end else begin
        logic [15:0] e;
        e = wr_q.pop_front();
        if ({O_wr_addr, O_wr_data} !== e) begin
          errors++;
          $display("FAIL wr_strobe got addr=%02h data=%02h, expected addr=%02h data=%02h",
                   O_wr_addr, O_wr_data, e[15:8], e[7:0]);
        end
      end
    end
  end

  // SDA must stay put while SCL is high unless the master itself moves it
  logic prev_line, prev_scl, prev_m, prev_rst;
  always @(negedge I_clk) begin
    if (I_rst_n && prev_rst && I_scl && prev_scl && !sda_m_low && !prev_m && sda_line !== prev_line)
      hold_viol++;
    prev_line = sda_line;
    prev_scl  = I_scl;
    prev_m    = sda_m_low;
    prev_rst  = I_rst_n;
  end

  // driver tasks
  task automatic wait_q(input int n);
    repeat (n) @(negedge I_clk);
  endtask

  task automatic start_cond();
    if (I_scl == 1'b0) begin
      sda_m_low = 1'b0;
      wait_q(Q);
      I_scl = 1'b1;
      wait_q(Q);
    end
    sda_m_low = 1'b1;
    wait_q(Q);
    I_scl = 1'b0;
    wait_q(Q);
  endtask

  task automatic stop_cond();
    sda_m_low = 1'b1;
    wait_q(Q);
    I_scl = 1'b1;
    wait_q(Q);
    sda_m_low = 1'b0;
    wait_q(Q);
  endtask

  task automatic bit_out(input logic b, output logic obs);
    sda_m_low = ~b;
    wait_q(Q);
    I_scl = 1'b1;
    wait_q(Q);
    obs = sda_line;
    wait_q(Q);
    I_scl = 1'b0;
    wait_q(Q);
  endtask

  task automatic bit_in(output logic b);
    sda_m_low = 1'b0;
    wait_q(Q);
    I_scl = 1'b1;
    wait_q(Q);
    b = sda_line;
    wait_q(Q);
    I_scl = 1'b0;
    wait_q(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic obs;
    for (int i = 7; i >= 0; i--) bit_out(d[i], obs);
    bit_in(ack);
  endtask

  task automatic read_byte(input logic master_nack, output logic [7:0] d, output logic obs);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(master_nack, obs);
  endtask

  task automatic expect_ack(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got ack_bit=%0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic write_txn(input logic [7:0] addr, input int n);
    logic ack;
    start_cond();
    write_byte(8'hA0, ack);
    expect_ack("wr_dev_ack", ack, 1'b0);
    write_byte(addr, ack);
    expect_ack("wr_word_ack", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = addr + 8'(i);
      wr_q.push_back({a, wbuf[i]});
      model_mem[a] = wbuf[i];
      write_byte(wbuf[i], ack);
      expect_ack("wr_data_ack", ack, 1'b0);
    end
    stop_cond();
    wait_q(4);
  endtask

  task automatic read_txn(input logic [7:0] addr, input int n);
    logic       ack;
    logic       obs;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] exp_ptr;
    start_cond();
    write_byte(8'hA0, ack);
    expect_ack("rd_dev_w_ack", ack, 1'b0);
    write_byte(addr, ack);
    expect_ack("rd_word_ack", ack, 1'b0);
    start_cond();
    write_byte(8'hA1, ack);
    expect_ack("rd_dev_r_ack", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(model_mem[addr + 8'(i)]);
      read_byte(i == n - 1, d, obs);
      e = rd_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL rd_byte got %02h, expected %02h", d, e);
      end
    end
    checks++;
    if (obs !== 1'b1) begin
      errors++;
      $display("FAIL nack_release got sda=%0b, expected 1", obs);
    end
    stop_cond();
    wait_q(4);
    exp_ptr = addr + 8'(n);
    checks++;
    if (O_rd_addr !== exp_ptr) begin
      errors++;
      $display("FAIL rd_pointer got %02h, expected %02h", O_rd_addr, exp_ptr);
    end
  endtask

  // scenarios
  task automatic test_reset();
    I_rst_n   = 1'b0;
    I_scl     = 1'b1;
    sda_m_low = 1'b0;
    wait_q(5);
    checks++;
    if ({O_wr_en, O_busy, O_rd_addr, sda_line} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got wr_en=%0b busy=%0b ptr=%02h sda=%0b, expected 0 0 00 1",
               O_wr_en, O_busy, O_rd_addr, sda_line);
    end
    I_rst_n = 1'b1;
    wait_q(5);
  endtask

  task automatic test_write();
    logic ack;
    start_cond();
    wait_q(2);
    checks++;
    if (O_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %0b, expected 1", O_busy);
    end
    wr_q.push_back({8'h12, 8'h5A});
    model_mem[8'h12] = 8'h5A;
    write_byte(8'hA0, ack);
    expect_ack("w_dev_ack", ack, 1'b0);
    write_byte(8'h12, ack);
    expect_ack("w_word_ack", ack, 1'b0);
    write_byte(8'h5A, ack);
    expect_ack("w_data_ack", ack, 1'b0);
    checks++;
    if (O_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_stop got %0b, expected 1", O_busy);
    end
    stop_cond();
    wait_q(4);
    checks++;
    if (O_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_stop got %0b, expected 0", O_busy);
    end
  endtask

  task automatic test_read();
    wbuf[0] = 8'hC3;
    write_txn(8'h34, 1);
    read_txn(8'h34, 1);
  endtask

  task automatic test_burst_wrap();
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    write_txn(8'hFE, 3);
    read_txn(8'hFE, 3);
  endtask

  task automatic test_random_burst();
    logic [7:0] a;
    a = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
    write_txn(a, 4);
    read_txn(a, 4);
  endtask

  task automatic test_wrong_addr();
    logic ack;
    start_cond();
    write_byte(8'hA2, ack);
    expect_ack("wrong_dev_nack", ack, 1'b1);
    write_byte(8'h00, ack);
    expect_ack("wrong_ignored", ack, 1'b1);
    stop_cond();
    wait_q(4);
    wbuf[0] = 8'h99;
    write_txn(8'h40, 1);
    read_txn(8'h40, 1);
  endtask

  task automatic test_abort();
    logic ack;
    logic obs;
    start_cond();
    write_byte(8'hA0, ack);
    expect_ack("abort_dev_ack", ack, 1'b0);
    write_byte(8'h50, ack);
    expect_ack("abort_word_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(i[0], obs);
    stop_cond();
    wait_q(4);
    checks++;
    if ({O_busy, sda_line, O_rd_addr} !== {1'b0, 1'b1, 8'h50}) begin
      errors++;
      $display("FAIL abort_idle got busy=%0b sda=%0b ptr=%02h, expected 0 1 50", O_busy, sda_line, O_rd_addr);
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    start_cond();
    write_byte(8'hA0, ack);
    expect_ack("rst_dev_w_ack", ack, 1'b0);
    write_byte(8'h12, ack);
    expect_ack("rst_word_ack", ack, 1'b0);
    start_cond();
    write_byte(8'hA1, ack);
    expect_ack("rst_dev_r_ack", ack, 1'b0);
    checks++;
    if (sda_line !== 1'b0) begin
      errors++;
      $display("FAIL rd_bit7_driven got sda=%0b, expected 0", sda_line);
    end
    I_rst_n = 1'b0;
    #1;
    checks++;
    if ({sda_line, O_rd_addr, O_busy} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got sda=%0b ptr=%02h busy=%0b, expected 1 00 0", sda_line, O_rd_addr, O_busy);
    end
    wait_q(3);
    I_scl = 1'b1;
    wait_q(Q);
    I_rst_n = 1'b1;
    wait_q(Q);
    read_txn(8'h12, 1);
  endtask

  task automatic test_sda_hold();
    checks++;
    if (hold_viol !== 0) begin
      errors++;
      $display("FAIL sda_hold got %0d changes while SCL high, expected 0", hold_viol);
    end
    checks++;
    if (wr_q.size() !== 0) begin
      errors++;
      $display("FAIL wr_missing got %0d writes outstanding, expected 0", wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst_wrap();
    test_random_burst();
    test_wrong_addr();
    test_abort();
    test_reset_mid_read();
    test_sda_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
